fb_scanout_reader: RTL and testbench
====================================

Name: fb_scanout_reader

Overview:
- Avalon-MM read master that fetches one full frame from the framebuffer that gpu_core writes.
- Layout: one 32-bit word per pixel; address = base + (y*640 + x)*4.
- Buffers returned words in an internal FIFO and presents them as a valid/ready pixel stream with start-of-frame and end-of-line markers to the display side.
- It is the reader counterpart of the GPU master write path.

Parameters:
- H_RES, 640, pixels per line
- V_RES, 480, lines per frame
- FIFO_DEPTH, 16, pixel FIFO entries (power of two, 4..64)
- MAX_OUTSTANDING, 8, cap on reads accepted but not yet returned

Ports:
- CLK  in  1  system clock, all logic on rising edge
- RESET  in  1  asynchronous, active-high reset
- frame_start  in  1  single-cycle request to scan one frame
- fb_base  in  32  byte base address of frame, sampled on accepted frame_start, must be 4-aligned
- M_address  out  32  Avalon read address
- M_read  out  1  Avalon read request
- M_readdata  in  32  Avalon read data
- M_readdatavalid  in  1  read data valid
- M_waitrequest  in  1  slave stall
- M_response  in  2  response code, 00 = OKAY
- pix_data  out  24  RGB = word[23:0]
- pix_valid  out  1  pixel available
- pix_ready  in  1  consumer accepts pixel
- pix_sof  out  1  qualifies pix_data as pixel (0,0)
- pix_eol  out  1  qualifies pix_data as x = H_RES-1
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse when the last pixel is accepted
- resp_err  out  1  sticky flag: a non-OKAY response was seen

Behaviour:
- Reset (asynchronous): all outputs 0, state IDLE, FIFO empty, outstanding = 0, request and pixel counters = 0, resp_err = 0.
- State IDLE: busy = 0. frame_start = 1 latches fb_base, clears counters, goes to FETCH next cycle.
- State FETCH:
  - M_read asserted when (fifo_count + outstanding) < FIFO_DEPTH, outstanding < MAX_OUTSTANDING, and req_cnt < H_RES*V_RES.
  - A read is accepted when M_read = 1 and M_waitrequest = 0. On acceptance: M_address += 4, req_cnt++, outstanding++.
  - While M_waitrequest = 1, M_read and M_address are held stable. The request is never withdrawn once raised.
  - When req_cnt reaches H_RES*V_RES, go to DRAIN and deassert M_read.
- State DRAIN: when outstanding = 0, FIFO empty and the last pixel is accepted, pulse frame_done and return to IDLE.
- Returned data:
  - M_readdatavalid = 1 pushes M_readdata[23:0] into the FIFO and decrements outstanding.
  - If M_response != 00, push 0x000000 instead and set resp_err.
  - If outstanding = 0, M_readdatavalid is ignored; this covers stale returns after a reset.
  - The credit rule guarantees the FIFO never overflows. An overflow is a design error, covered by a bench assertion.
- A cycle with both an accepted read and a valid return leaves outstanding unchanged. A simultaneous FIFO push and pop leaves fifo_count unchanged.
- Pixel stream:
  - pix_valid = FIFO not empty.
  - A pop happens on pix_valid & pix_ready.
  - pix_data, pix_sof and pix_eol are stable while pix_valid & !pix_ready.
  - Output counters px (0..H_RES-1) and py (0..V_RES-1) advance on pop. px wraps to 0 and py increments at H_RES-1.
  - pix_sof = (px = 0 & py = 0); pix_eol = (px = H_RES-1).
- Latency: from first read acceptance, the earliest pix_valid is the cycle after the first M_readdatavalid (registered FIFO).
- frame_start while busy is ignored; fb_base is not resampled.
- Address arithmetic is 32-bit unsigned and wraps modulo 2^32. No bounds check.
- Reset mid-frame returns to IDLE immediately and drops buffered pixels. No frame_done pulse.

Test Plan:
- Zero-wait slave (1-cycle latency), pix_ready = 1, fb_base = 0, memory word n = n -> 307200 reads at addresses 0,4,…,0x12BFFC. Pixels appear in order. pix_sof only on pixel 0. pix_eol on pixels 639, 1279, …. frame_done exactly once, after pixel 307199.
- pix_ready = 0 for 100 cycles after start, slave latency 3 -> M_read stops once fifo_count + outstanding = 16, with no overflow. After release, data continuity holds.
- M_waitrequest toggled randomly (50%), fb_base = 0x00100000 -> M_address/M_read stable during stalls. First address 0x00100000, last address 0x0022BFFC.
- M_response = 10 on read index 5 -> pixel 5 = 0x000000, resp_err = 1 and stays set until reset. Other pixels unaffected.
- Second frame_start pulse with a different fb_base at cycle 50 of the frame -> ignored; addresses continue from the original base.
- RESET asserted with 4 reads outstanding, then M_readdatavalid returns 4 stale words -> outputs 0, FIFO stays empty, no pix_valid. The next frame_start runs a clean frame.

Source files
------------

// File: rtl/fb_scanout_reader_if.sv
// fb_scanout_reader_if: Avalon-MM read bus plus the valid/ready pixel stream of the scanout reader.
interface fb_scanout_reader_if;
    logic [31:0] M_address;
    logic        M_read;
    logic [31:0] M_readdata;
    logic        M_readdatavalid;
    logic        M_waitrequest;
    logic [1:0]  M_response;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_sof;
    logic        pix_eol;
    modport master (
        output M_address, M_read, pix_data, pix_valid, pix_sof, pix_eol,
        input  M_readdata, M_readdatavalid, M_waitrequest, M_response, pix_ready
    );
    modport slave (
        input  M_address, M_read, pix_data, pix_valid, pix_sof, pix_eol,
        output M_readdata, M_readdatavalid, M_waitrequest, M_response, pix_ready
    );
endinterface

// File: rtl/fb_scanout_reader.sv
// fb_scanout_reader: fetches one framebuffer frame over Avalon-MM and streams it out as pixels.
module fb_scanout_reader #(
    parameter int H_RES           = 640,
    parameter int V_RES           = 480,
    parameter int FIFO_DEPTH      = 16,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       frame_start,
    input  logic [31:0]                fb_base,
    fb_scanout_reader_if.master        bus,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       resp_err
);
    localparam int TOTAL = H_RES * V_RES;
    localparam int RW    = $clog2(TOTAL + 1);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;
    localparam int OW    = $clog2(MAX_OUTSTANDING + 1);
    localparam int XW    = $clog2(H_RES + 1);
    localparam int YW    = $clog2(V_RES + 1);
    localparam int SW    = (CW > OW ? CW : OW) + 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
    state_t state, state_nx;

    logic [31:0]   addr;
    logic [RW-1:0] req_cnt;
    logic [OW-1:0] outst;
    logic [AW-1:0] wp, rp;
    logic [CW-1:0] cnt;
    logic [XW-1:0] px;
    logic [YW-1:0] py;
    logic [23:0]   mem [FIFO_DEPTH];
    logic          start, accept, ret, pop, col_last, row_last;
    logic          unused_hi;

    assign unused_hi = &{1'b0, bus.M_readdata[31:24]};
    assign start     = state == IDLE && frame_start;
    assign accept    = bus.M_read && !bus.M_waitrequest;
    // returns with nothing in flight are stale (e.g. from before a reset) and are dropped
    assign ret       = bus.M_readdatavalid && outst != '0;
    assign pop       = bus.pix_valid && bus.pix_ready;
    assign col_last  = px == XW'(H_RES - 1);
    assign row_last  = py == YW'(V_RES - 1);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = frame_start ? FETCH : IDLE;
            FETCH:   state_nx = accept && req_cnt == RW'(TOTAL - 1) ? DRAIN : FETCH;
            DRAIN:   state_nx = frame_done ? IDLE : DRAIN;
            default: state_nx = IDLE;
        endcase
    end

    // credit rule: every request in flight already owns a FIFO slot, so the FIFO cannot overflow
    always_comb begin
        busy       = state != IDLE;
        bus.M_read = state == FETCH && SW'(cnt) + SW'(outst) < SW'(FIFO_DEPTH)
                     && outst < OW'(MAX_OUTSTANDING) && req_cnt < RW'(TOTAL);
        frame_done = state == DRAIN && pop && col_last && row_last;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            addr     <= '0;
            req_cnt  <= '0;
            outst    <= '0;
            wp       <= '0;
            rp       <= '0;
            cnt      <= '0;
            px       <= '0;
            py       <= '0;
            resp_err <= 1'b0;
        end else begin
            if (start) begin
                addr    <= fb_base;
                req_cnt <= '0;
            end else if (accept) begin
                addr    <= addr + 32'd4;
                req_cnt <= req_cnt + RW'(1);
            end
            outst <= outst + OW'(accept) - OW'(ret);
            cnt   <= cnt + CW'(ret) - CW'(pop);
            if (ret) wp <= wp + AW'(1);
            if (pop) rp <= rp + AW'(1);
            if (ret && bus.M_response != 2'b00) resp_err <= 1'b1;
            if (start) begin
                px <= '0;
                py <= '0;
            end else if (pop) begin
                px <= col_last ? '0 : px + XW'(1);
                py <= !col_last ? py : row_last ? '0 : py + YW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (ret) mem[wp] <= bus.M_response == 2'b00 ? bus.M_readdata[23:0] : 24'h0;
    end

    assign bus.M_address = addr;
    assign bus.pix_valid = cnt != '0;
    assign bus.pix_data  = bus.pix_valid ? mem[rp] : 24'h0;
    assign bus.pix_sof   = bus.pix_valid && px == '0 && py == '0;
    assign bus.pix_eol   = bus.pix_valid && col_last;
endmodule

// File: tb/tb_fb_scanout_reader.sv
// tb_fb_scanout_reader: random Avalon slave and pixel sink against a frame-level reference model.
module tb_fb_scanout_reader;
    localparam int H = 10, V = 6, TOTAL = H * V, DEPTH = 16, MAXO = 8;

    logic CLK = 1'b0, RESET = 1'b1, frame_start = 1'b0;
    logic [31:0] fb_base = '0;
    logic busy, frame_done, resp_err;

    fb_scanout_reader_if bus();

    fb_scanout_reader #(.H_RES(H), .V_RES(V), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
        .CLK(CLK), .RESET(RESET), .frame_start(frame_start), .fb_base(fb_base),
        .bus(bus.master), .busy(busy), .frame_done(frame_done), .resp_err(resp_err)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0, n_fail = 0, cyc = 0, last_due = 0;
    int req_m = 0, pix_m = 0, out_m = 0, fifo_m = 0, done_cnt = 0, err_idx = -1;
    int wait_mode = 0, ready_mode = 0, lat_lo = 1, lat_hi = 1, hold_start = 0;
    bit busy_m = 0, err_m = 0, prev_stall = 0, in_reset = 1;
    logic [31:0] base_m = '0, prev_addr = '0, last_addr_m = '0;
    int due_q[$], idx_q[$];
    logic [31:0] addr_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h00A5_5A00;
    endfunction

    function automatic logic [23:0] exp_pix(input int n);
        logic [31:0] w;
        w = word(base_m + 32'(n) * 4);
        return n == err_idx ? 24'h0 : w[23:0];
    endfunction

    task automatic tick();
        bit acc, pop, done_e, b0;
        int o0, due;
        @(negedge CLK);
        acc = bus.M_read && !bus.M_waitrequest;
        pop = bus.pix_valid && bus.pix_ready;
        if (in_reset) begin
            chk("rst_busy", busy, 0);
            chk("rst_read", bus.M_read, 0);
            chk("rst_addr", bus.M_address, 0);
            chk("rst_valid", bus.pix_valid, 0);
            chk("rst_data", bus.pix_data, 0);
            chk("rst_sof", bus.pix_sof, 0);
            chk("rst_eol", bus.pix_eol, 0);
            chk("rst_done", frame_done, 0);
            chk("rst_err", resp_err, 0);
        end else begin
            o0 = out_m;
            b0 = busy_m;
            chk("m_read", bus.M_read, busy_m && req_m < TOTAL && fifo_m + out_m < DEPTH && out_m < MAXO);
            chk("busy", busy, busy_m);
            chk("pix_valid", bus.pix_valid, fifo_m > 0);
            chk("resp_err", resp_err, err_m);
            if (prev_stall) chk("stall_addr", bus.M_address, prev_addr);
            if (acc) begin
                chk("addr", bus.M_address, base_m + 32'(req_m) * 4);
                due = cyc + int'($urandom_range(lat_lo, lat_hi));
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                due_q.push_back(due);
                idx_q.push_back(req_m);
                addr_q.push_back(bus.M_address);
                last_addr_m = bus.M_address;
                req_m++;
                out_m++;
            end
            if (pop) begin
                chk("pix_data", bus.pix_data, exp_pix(pix_m));
                chk("pix_sof", bus.pix_sof, pix_m == 0);
                chk("pix_eol", bus.pix_eol, pix_m % H == H - 1);
            end
            done_e = pop && pix_m == TOTAL - 1;
            chk("frame_done", frame_done, done_e);
            if (bus.M_readdatavalid && o0 > 0) begin
                fifo_m++;
                out_m--;
                if (bus.M_response != 2'b00) err_m = 1;
                chk("no_overflow", fifo_m <= DEPTH, 1);
            end
            if (pop) begin
                fifo_m--;
                pix_m++;
            end
            if (done_e) begin
                busy_m = 0;
                done_cnt++;
            end
            if (frame_start && !b0) begin
                busy_m = 1;
                base_m = fb_base;
                req_m = 0;
                pix_m = 0;
            end
        end
        prev_stall = !in_reset && bus.M_read && bus.M_waitrequest;
        prev_addr = bus.M_address;
        @(posedge CLK);
        #1;
        cyc++;
        bus.M_waitrequest = wait_mode != 0 ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.pix_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? 1'($urandom_range(0, 1)) :
                        ready_mode == 2 ? (cyc - hold_start >= 100) : 1'b0;
        if (due_q.size() > 0 && due_q[0] <= cyc) begin
            bus.M_readdatavalid = 1'b1;
            bus.M_readdata = word(addr_q[0]);
            bus.M_response = idx_q[0] == err_idx ? 2'b10 : 2'b00;
            void'(due_q.pop_front());
            void'(idx_q.pop_front());
            void'(addr_q.pop_front());
        end else begin
            bus.M_readdatavalid = 1'b0;
            bus.M_readdata = $urandom;
            bus.M_response = 2'($urandom);
        end
    endtask

    task automatic run_frame(input logic [31:0] base, input int restart_at);
        int i;
        done_cnt = 0;
        hold_start = cyc;
        fb_base = base;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        i = 0;
        while (busy_m && i < 4000) begin
            if (i == restart_at) begin
                fb_base = ~base & ~32'h3;
                frame_start = 1'b1;
            end
            if (ready_mode == 2 && cyc - hold_start == 99) chk("credit_fill", req_m, DEPTH);
            tick();
            frame_start = 1'b0;
            i++;
        end
        chk("timeout", busy_m, 0);
        chk("done_once", done_cnt, 1);
        chk("reads", req_m, TOTAL);
        chk("pixels", pix_m, TOTAL);
        chk("last_addr", last_addr_m, base + 32'(TOTAL - 1) * 4);
    endtask

    initial begin
        bus.M_readdata = '0;
        bus.M_readdatavalid = 1'b0;
        bus.M_waitrequest = 1'b0;
        bus.M_response = 2'b00;
        bus.pix_ready = 1'b0;
        repeat (2) tick();
        RESET = 1'b0;
        in_reset = 0;
        repeat (2) tick();

        run_frame(32'h0000_0000, -1);

        lat_lo = 3; lat_hi = 3; ready_mode = 2;
        run_frame(32'h0000_0040, -1);

        lat_lo = 1; lat_hi = 4; wait_mode = 1; ready_mode = 1;
        run_frame(32'h0010_0000, -1);

        err_idx = 5; wait_mode = 0; ready_mode = 0; lat_lo = 1; lat_hi = 2;
        run_frame(32'h0000_0200, -1);
        chk("err_sticky", resp_err, 1);
        err_idx = -1;

        ready_mode = 1;
        run_frame(32'h0000_3000, 50);
        chk("err_kept", resp_err, 1);

        lat_lo = 20; lat_hi = 20; ready_mode = 3;
        fb_base = 32'h0000_5000;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int i = 0; i < 50 && out_m < 4; i++) tick();
        chk("four_out", out_m, 4);
        RESET = 1'b1;
        in_reset = 1;
        busy_m = 0; out_m = 0; fifo_m = 0; req_m = 0; pix_m = 0; err_m = 0;
        tick();
        RESET = 1'b0;
        in_reset = 0;
        ready_mode = 0;
        repeat (30) tick();
        chk("stale_drained", due_q.size(), 0);
        chk("stale_valid", bus.pix_valid, 0);

        lat_lo = 1; lat_hi = 3; wait_mode = 1; ready_mode = 1;
        run_frame(32'hFFFF_FFC0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
